// File: rtl/iter_ctrl_pkg.sv
`default_nettype none
// =============================================================================
// Module   : iter_ctrl_pkg
// Brief    : State encoding and default sizing for the iteration sequencer.
// Revision : 1.0
// =============================================================================
package iter_ctrl_pkg;

    localparam int CNTW_DEFAULT    = 5;
    localparam int MAXITER_DEFAULT = 31;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } iter_state_t;

endpackage
`default_nettype wire

// File: rtl/iter_cnt.sv
`default_nettype none
// =============================================================================
// Module   : iter_cnt
// Brief    : Saturating down-counter with sync clear/load, enable and IsOne flag.
// Revision : 1.0
// =============================================================================
module iter_cnt #(
    parameter int CNTW = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_clr,
    input  logic            i_load,
    input  logic [CNTW-1:0] i_load_val,
    input  logic            i_en,
    output logic [CNTW-1:0] o_cnt,
    output logic            o_is_one
);

    logic [CNTW-1:0] r_cnt;

    // Clear outranks load; decrement stops at zero so the count never wraps.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_cnt <= '0;
        else if (i_clr)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= i_load_val;
        else if (i_en && (r_cnt != '0))
            r_cnt <= r_cnt - CNTW'(1);
    end

    assign o_cnt    = r_cnt;
    assign o_is_one = (r_cnt == CNTW'(1));

endmodule
`default_nettype wire

// File: rtl/iter_ctrl.sv
`default_nettype none
// =============================================================================
// Module   : iter_ctrl
// Brief    : Load-then-iterate sequencer; optional EarlyTerm port enabled by
//            defining ITER_CTRL_EARLY_TERM_EN.
// Revision : 1.0
// =============================================================================
module iter_ctrl
    import iter_ctrl_pkg::*;
#(
    parameter int CNTW    = CNTW_DEFAULT,
    parameter int MAXITER = MAXITER_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            Start,
    input  logic [CNTW-1:0] NumIter,
    input  logic            Stall,
    input  logic            Flush,
    input  logic            Ack,
`ifdef ITER_CTRL_EARLY_TERM_EN
    input  logic            EarlyTerm,
`endif
    output logic            Ready,
    output logic            Load,
    output logic            En,
    output logic            Busy,
    output logic            Done,
    output logic [CNTW-1:0] IterCnt
);

    iter_state_t     r_state;
    logic            w_accept;
    logic            w_en;
    logic            w_early;
    logic            w_clr;
    logic            w_is_one;
    logic [CNTW-1:0] w_load_val;

`ifdef ITER_CTRL_EARLY_TERM_EN
    assign w_early = EarlyTerm;
`else
    assign w_early = 1'b0;
`endif

    assign w_accept   = (r_state == IDLE) && Start && !Flush;
    assign w_en       = (r_state == BUSY) && !Stall && !Flush;
    assign w_clr      = Flush || (w_en && w_early);
    assign w_load_val = (NumIter > CNTW'(MAXITER)) ? CNTW'(MAXITER) : NumIter;

    iter_cnt #(
        .CNTW       (CNTW)
    ) u_cnt (
        .clk        (clk),
        .reset      (reset),
        .i_clr      (w_clr),
        .i_load     (w_accept),
        .i_load_val (w_load_val),
        .i_en       (w_en),
        .o_cnt      (IterCnt),
        .o_is_one   (w_is_one)
    );

    // Flush wins over every other transition, including Ack and EarlyTerm.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= IDLE;
        else if (Flush)
            r_state <= IDLE;
        else begin
            case (r_state)
                IDLE:    if (w_accept) r_state <= (w_load_val == '0) ? DONE : BUSY;
                BUSY:    if (w_en && (w_is_one || w_early)) r_state <= DONE;
                DONE:    if (Ack) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign Ready = (r_state == IDLE) && !Flush;
    assign Load  = w_accept;
    assign En    = w_en;
    assign Busy  = (r_state == BUSY) || (r_state == DONE);
    assign Done  = (r_state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_iter_ctrl.sv
`default_nettype none
// =============================================================================
// Module   : tb_iter_ctrl
// Brief    : Directed self-checking bench for iter_ctrl (MAXITER=20 instance).
// Revision : 1.0
// =============================================================================
module tb_iter_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       Start, Stall, Flush, Ack, EarlyTerm;
    logic [4:0] NumIter;
    logic       Ready, Load, En, Busy, Done;
    logic [4:0] IterCnt;

    int n_err    = 0;
    int n_checks = 0;
    int n_en;

    always #5 clk = ~clk;

    iter_ctrl #(
        .CNTW      (5),
        .MAXITER   (20)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .Start     (Start),
        .NumIter   (NumIter),
        .Stall     (Stall),
        .Flush     (Flush),
        .Ack       (Ack),
`ifdef ITER_CTRL_EARLY_TERM_EN
        .EarlyTerm (EarlyTerm),
`endif
        .Ready     (Ready),
        .Load      (Load),
        .En        (En),
        .Busy      (Busy),
        .Done      (Done),
        .IterCnt   (IterCnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt_b [8] = '{0, 4, 3, 3, 3, 2, 1, 0};
        reset = 1'b1; Start = 0; Stall = 0; Flush = 0; Ack = 0; EarlyTerm = 0; NumIter = 0;
        #2;
        chk("rst_ready", Ready, 1);
        chk("rst_load", Load, 0);
        chk("rst_en", En, 0);
        chk("rst_done", Done, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_cnt", IterCnt, 0);
        #6 reset = 1'b0;
        tick();

        // NumIter=4, no stall; Ack in cycle 7
        Start = 1; NumIter = 4; #1;
        chk("a_load0", Load, 1);
        chk("a_en0", En, 0);
        for (int c = 1; c <= 7; c++) begin
            tick(); Start = 0; Ack = (c == 7); #1;
            chk($sformatf("a_en%0d", c), En, (c >= 1 && c <= 4));
            chk($sformatf("a_done%0d", c), Done, (c >= 5));
            chk($sformatf("a_cnt%0d", c), IterCnt, (c <= 4) ? 5 - c : 0);
            chk($sformatf("a_load%0d", c), Load, 0);
        end
        tick(); Ack = 0; #1;
        chk("a_ready8", Ready, 1);
        chk("a_busy8", Busy, 0);

        // NumIter=4, Stall in cycles 2-3
        Start = 1; NumIter = 4; #1;
        chk("b_load0", Load, 1);
        for (int c = 1; c <= 7; c++) begin
            tick(); Start = 0; Stall = (c == 2 || c == 3); Ack = (c == 7); #1;
            chk($sformatf("b_en%0d", c), En, (c == 1 || (c >= 4 && c <= 6)));
            chk($sformatf("b_done%0d", c), Done, (c == 7));
            chk($sformatf("b_cnt%0d", c), IterCnt, cnt_b[c]);
        end
        tick(); Ack = 0; Stall = 0; #1;
        chk("b_ready8", Ready, 1);

        // NumIter=0: Load, then Done next cycle with no En
        Start = 1; NumIter = 0; #1;
        chk("c_load0", Load, 1);
        tick(); Start = 0; #1;
        chk("c_done1", Done, 1);
        chk("c_en1", En, 0);
        chk("c_busy1", Busy, 1);
        Ack = 1; Stall = 1; #1;
        tick(); Ack = 0; Stall = 0; #1;
        chk("c_ready2", Ready, 1);

        // NumIter=31 saturates to MAXITER=20
        Start = 1; NumIter = 31; #1;
        tick(); Start = 0; #1;
        chk("d_cnt1", IterCnt, 20);
        n_en = En ? 1 : 0;
        for (int c = 2; c <= 40 && !Done; c++) begin
            tick(); #1;
            if (En) n_en++;
        end
        chk("d_done", Done, 1);
        chk("d_en_count", n_en, 20);
        Ack = 1; tick(); Ack = 0; #1;
        chk("d_ready", Ready, 1);

        // Flush with Start in IDLE
        Start = 1; Flush = 1; NumIter = 3; #1;
        chk("e_load", Load, 0);
        chk("e_ready", Ready, 0);
        tick(); Start = 0; Flush = 0; #1;
        chk("e_busy", Busy, 0);
        chk("e_cnt", IterCnt, 0);

        // Flush at IterCnt=2
        Start = 1; NumIter = 4; #1;
        tick(); Start = 0; tick(); tick(); #1;
        chk("f_cnt2", IterCnt, 2);
        Flush = 1; #1;
        chk("f_en_flush", En, 0);
        tick(); Flush = 0; #1;
        chk("f_ready", Ready, 1);
        chk("f_busy", Busy, 0);
        chk("f_cnt0", IterCnt, 0);
        tick(); tick(); #1;
        chk("f_nodone", Done, 0);

        // Flush with Ack in DONE, then Flush alone in DONE
        Start = 1; NumIter = 0; #1;
        tick(); Start = 0; #1;
        chk("g_done", Done, 1);
        Ack = 1; Flush = 1; #1;
        tick(); Ack = 0; Flush = 0; #1;
        chk("g_ready_ack", Ready, 1);
        chk("g_done_clr", Done, 0);
        Start = 1; NumIter = 0; #1;
        tick(); Start = 0; Flush = 1; #1;
        tick(); Flush = 0; #1;
        chk("g_flush_only", Done, 0);
        chk("g_flush_ready", Ready, 1);

        // Start while busy is ignored
        Start = 1; NumIter = 4; #1;
        tick(); Start = 0; tick(); Start = 1; NumIter = 9; #1;
        chk("h_noload", Load, 0);
        tick(); Start = 0; #1;
        chk("h_cnt", IterCnt, 2);
        tick(); tick(); #1;
        chk("h_done", Done, 1);
        Ack = 1; tick(); Ack = 0; #1;
        chk("h_ready", Ready, 1);

        // Async reset mid-BUSY at IterCnt=3
        Start = 1; NumIter = 4; #1;
        tick(); Start = 0; tick(); #1;
        chk("i_cnt3", IterCnt, 3);
        reset = 1; #1;
        chk("i_rst_busy", Busy, 0);
        chk("i_rst_cnt", IterCnt, 0);
        chk("i_rst_en", En, 0);
        chk("i_rst_ready", Ready, 1);
        reset = 0;
        tick();
        Start = 1; NumIter = 2; #1;
        chk("i_load", Load, 1);
        tick(); Start = 0; #1;
        chk("i_cnt_after", IterCnt, 2);
        tick(); tick(); #1;
        chk("i_done", Done, 1);
        Ack = 1; tick(); Ack = 0; #1;

`ifdef ITER_CTRL_EARLY_TERM_EN
        // NumIter=8, EarlyTerm in cycle 3
        Start = 1; NumIter = 8; #1;
        for (int c = 1; c <= 4; c++) begin
            tick(); Start = 0; EarlyTerm = (c == 3); #1;
            chk($sformatf("j_en%0d", c), En, (c <= 3));
            chk($sformatf("j_done%0d", c), Done, (c == 4));
        end
        EarlyTerm = 0; #1;
        chk("j_cnt", IterCnt, 0);
        Ack = 1; tick(); Ack = 0; #1;
        chk("j_ready", Ready, 1);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
